// File: rtl/bf_jump_linker_if.sv
// Bus between the jump linker, program memory and jump table.
// The master side is the controller/memory; the slave side is the linker.
interface bf_jump_linker_if #(
   parameter int AW = 8
);
   logic          start;
   logic          busy;
   logic          done;
   logic          err;
   logic [1:0]    err_code;
   logic [AW-1:0] err_addr;
   logic [AW-1:0] prog_addr;
   logic [7:0]    prog_data;
   logic          jt_wr;
   logic [AW-1:0] jt_addr;
   logic [AW-1:0] jt_data;

   modport master (
      output start, prog_data,
      input  busy, done, err, err_code, err_addr, prog_addr, jt_wr, jt_addr, jt_data
   );

   modport slave (
      input  start, prog_data,
      output busy, done, err, err_code, err_addr, prog_addr, jt_wr, jt_addr, jt_data
   );
endinterface

// File: rtl/bf_jump_linker.sv
// Pre-run bracket matcher: scans program memory once and writes both
// directions of every matched [ ] pair into the jump table.
module bf_jump_linker #(
   parameter int AW    = 8,
   parameter int DEPTH = 16,
   parameter int SPW   = 5
) (
   input  logic             clk,
   input  logic             nrst,
   bf_jump_linker_if.slave  bus
);
   localparam int         IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [7:0] CH_OPEN  = 8'h5B;
   localparam logic [7:0] CH_CLOSE = 8'h5D;
   localparam logic [7:0] CH_END   = 8'h00;

   typedef enum logic [2:0] {S_IDLE, S_SCAN, S_LINK, S_DONE, S_ERR} state_t;

   state_t                   state_q;
   logic [AW-1:0]            pc_q;
   logic [SPW-1:0]           sp_q;
   logic [DEPTH-1:0][AW-1:0] stack_q;
   logic                     busy_q, done_q, err_q;
   logic [1:0]               code_q;
   logic [AW-1:0]            eaddr_q;

   logic [SPW-1:0] sp_m1, sp_m2;
   logic [AW-1:0]  top, below;
   logic           last, sp_full, sp_empty, push;

   assign sp_m1    = sp_q - SPW'(1);
   assign sp_m2    = sp_q - SPW'(2);
   assign top      = stack_q[sp_m1[IW-1:0]];
   assign below    = stack_q[sp_m2[IW-1:0]];
   assign last     = &pc_q;
   assign sp_full  = (sp_q == SPW'(DEPTH));
   assign sp_empty = (sp_q == '0);
   assign push     = (state_q == S_SCAN) && (bus.prog_data == CH_OPEN) && !sp_full;

   // Stack contents need no reset: entries are only read below sp.
   always_ff @(posedge clk) begin
      if (push) stack_q[sp_q[IW-1:0]] <= pc_q;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q <= S_IDLE;
         pc_q    <= '0;
         sp_q    <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= 2'd0;
         eaddr_q <= '0;
      end else begin
         case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
               if (bus.start) begin
                  state_q <= S_SCAN;
                  pc_q    <= '0;
                  sp_q    <= '0;
                  busy_q  <= 1'b1;
                  done_q  <= 1'b0;
                  err_q   <= 1'b0;
                  code_q  <= 2'd0;
               end
            end
            S_SCAN: begin
               case (bus.prog_data)
                  CH_OPEN: begin
                     if (sp_full) begin
                        state_q <= S_ERR; busy_q <= 1'b0; err_q <= 1'b1;
                        code_q  <= 2'd3;  eaddr_q <= pc_q;
                     end else begin
                        sp_q <= sp_q + SPW'(1);
                        // A [ in the last slot can never close; it is the innermost open.
                        if (last) begin
                           state_q <= S_ERR; busy_q <= 1'b0; err_q <= 1'b1;
                           code_q  <= 2'd2;  eaddr_q <= pc_q;
                        end else begin
                           pc_q <= pc_q + AW'(1);
                        end
                     end
                  end
                  CH_CLOSE: begin
                     if (sp_empty) begin
                        state_q <= S_ERR; busy_q <= 1'b0; err_q <= 1'b1;
                        code_q  <= 2'd1;  eaddr_q <= pc_q;
                     end else begin
                        state_q <= S_LINK;
                     end
                  end
                  CH_END: begin
                     busy_q <= 1'b0;
                     if (sp_empty) begin
                        state_q <= S_DONE; done_q <= 1'b1;
                     end else begin
                        state_q <= S_ERR; err_q <= 1'b1;
                        code_q  <= 2'd2;  eaddr_q <= top;
                     end
                  end
                  default: begin
                     if (last) begin
                        busy_q <= 1'b0;
                        if (sp_empty) begin
                           state_q <= S_DONE; done_q <= 1'b1;
                        end else begin
                           state_q <= S_ERR; err_q <= 1'b1;
                           code_q  <= 2'd2;  eaddr_q <= top;
                        end
                     end else begin
                        pc_q <= pc_q + AW'(1);
                     end
                  end
               endcase
            end
            S_LINK: begin
               sp_q <= sp_m1;
               if (last) begin
                  busy_q <= 1'b0;
                  if (sp_q == SPW'(1)) begin
                     state_q <= S_DONE; done_q <= 1'b1;
                  end else begin
                     state_q <= S_ERR; err_q <= 1'b1;
                     code_q  <= 2'd2;  eaddr_q <= below;
                  end
               end else begin
                  state_q <= S_SCAN;
                  pc_q    <= pc_q + AW'(1);
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // First half of a link is written from SCAN on the ], second half from LINK.
   assign bus.jt_wr     = (state_q == S_LINK) ||
                          ((state_q == S_SCAN) && (bus.prog_data == CH_CLOSE) && !sp_empty);
   assign bus.jt_addr   = (state_q == S_LINK) ? top  : pc_q;
   assign bus.jt_data   = (state_q == S_LINK) ? pc_q : top;
   assign bus.prog_addr = pc_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;
   assign bus.err_code  = code_q;
   assign bus.err_addr  = eaddr_q;
endmodule

// File: tb/tb_bf_jump_linker.sv
// Bench for bf_jump_linker: program vectors plus a jump-table write scoreboard.
module tb_bf_jump_linker;
   localparam int AW    = 8;
   localparam int DEPTH = 16;
   localparam int SPW   = 5;

   logic clk  = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;

   bf_jump_linker_if #(.AW(AW)) bus ();
   logic [7:0] mem [0:255];
   assign bus.prog_data = mem[bus.prog_addr];

   bf_jump_linker #(.AW(AW), .DEPTH(DEPTH), .SPW(SPW)) dut (
      .clk  (clk),
      .nrst (nrst),
      .bus  (bus)
   );

   int checks = 0;
   int errors = 0;
   logic [2*AW-1:0] sbq [$];
   logic [2*AW-1:0] exp_wr;

   typedef struct packed {
      logic [8*48-1:0] prog;
      int poke, dn, er, code, addr, cyc;
   } vec_t;
   vec_t vecs [11];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (nrst && bus.jt_wr) begin
         chk("jt_wr_busy", int'(bus.busy), 1);
         if (sbq.size() == 0) begin
            checks++; errors++;
            $display("FAIL jt_unexpected: addr %0d data %0d, no write expected", bus.jt_addr, bus.jt_data);
         end else begin
            exp_wr = sbq.pop_front();
            chk("jt_addr", int'(bus.jt_addr), int'(exp_wr[2*AW-1:AW]));
            chk("jt_data", int'(bus.jt_data), int'(exp_wr[AW-1:0]));
         end
      end
   end

   task automatic fill(input logic [7:0] b);
      for (int i = 0; i < 256; i++) mem[i] = b;
   endtask

   task automatic load_str(input logic [8*48-1:0] p);
      int k;
      fill(8'h00);
      k = 0;
      for (int i = 47; i >= 0; i--) begin
         if (p[i*8 +: 8] != 8'h00) begin
            mem[k] = p[i*8 +: 8];
            k++;
         end
      end
   endtask

   // Reference bracket matcher producing the expected write sequence.
   task automatic model();
      int sp;
      int stk [DEPTH];
      logic [7:0] b;
      sp = 0;
      for (int a = 0; a < 256; a++) begin
         b = mem[a];
         if (b == 8'h00) break;
         if (b == 8'h5B) begin
            if (sp == DEPTH) break;
            stk[sp] = a;
            sp++;
         end else if (b == 8'h5D) begin
            if (sp == 0) break;
            sbq.push_back({AW'(a), AW'(stk[sp-1])});
            sbq.push_back({AW'(stk[sp-1]), AW'(a)});
            sp--;
         end
      end
   endtask

   task automatic run(input string nm, input int poke, input int dn, input int er,
                      input int code, input int addr, input int cyc);
      int cnt;
      model();
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      chk({nm, "_start_busy"}, int'(bus.busy), 1);
      chk({nm, "_start_err"}, int'(bus.err) + int'(bus.err_code) + int'(bus.done), 0);
      cnt = 0;
      while (!(bus.done || bus.err) && cnt < 3000) begin
         bus.start = (cnt == poke);
         @(posedge clk);
         #1;
         bus.start = 1'b0;
         cnt++;
      end
      if (cnt >= 3000) begin
         checks++; errors++;
         $display("FAIL %s_timeout: no done/err after %0d cycles, required %0d", nm, cnt, cyc);
      end
      chk({nm, "_cycles"}, cnt, cyc);
      chk({nm, "_done"}, int'(bus.done), dn);
      chk({nm, "_err"}, int'(bus.err), er);
      chk({nm, "_code"}, int'(bus.err_code), code);
      if (er != 0) chk({nm, "_addr"}, int'(bus.err_addr), addr);
      chk({nm, "_busy"}, int'(bus.busy), 0);
      chk({nm, "_pending_wr"}, sbq.size(), 0);
      sbq.delete();
   endtask

   initial begin
      bus.start = 1'b0;
      fill(8'h00);
      vecs[0]  = '{prog: "+[-]",             poke: -1, dn: 1, er: 0, code: 0, addr: 0,  cyc: 6};
      vecs[1]  = '{prog: "[[]][]",           poke: -1, dn: 1, er: 0, code: 0, addr: 0,  cyc: 10};
      vecs[2]  = '{prog: "+]",               poke: -1, dn: 0, er: 1, code: 1, addr: 1,  cyc: 2};
      vecs[3]  = '{prog: "[[]",              poke: -1, dn: 0, er: 1, code: 2, addr: 0,  cyc: 5};
      vecs[4]  = '{prog: "[[[[[[[[[[[[[[[[[", poke: -1, dn: 0, er: 1, code: 3, addr: 16, cyc: 17};
      vecs[5]  = '{prog: "+[-]",             poke: -1, dn: 1, er: 0, code: 0, addr: 0,  cyc: 6};
      vecs[6]  = '{prog: "",                 poke: -1, dn: 1, er: 0, code: 0, addr: 0,  cyc: 1};
      vecs[7]  = '{prog: "]",                poke: -1, dn: 0, er: 1, code: 1, addr: 0,  cyc: 1};
      vecs[8]  = '{prog: "[]a[",             poke: -1, dn: 0, er: 1, code: 2, addr: 3,  cyc: 6};
      vecs[9]  = '{prog: "[[[[[[[[[[[[[[[[]]]]]]]]]]]]]]]]", poke: -1, dn: 1, er: 0, code: 0, addr: 0, cyc: 49};
      vecs[10] = '{prog: "+[-]",             poke: 2,  dn: 1, er: 0, code: 0, addr: 0,  cyc: 6};

      #1;
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done_err", int'(bus.done) + int'(bus.err), 0);
      chk("rst_code", int'(bus.err_code), 0);
      chk("rst_err_addr", int'(bus.err_addr), 0);
      chk("rst_prog_addr", int'(bus.prog_addr), 0);
      chk("rst_jt_wr", int'(bus.jt_wr), 0);
      repeat (2) @(negedge clk);
      nrst = 1'b1;

      for (int i = 0; i < 11; i++) begin
         load_str(vecs[i].prog);
         run($sformatf("vec%0d", i), vecs[i].poke, vecs[i].dn, vecs[i].er,
             vecs[i].code, vecs[i].addr, vecs[i].cyc);
      end

      fill(8'h2B);
      run("last_plain", -1, 1, 0, 0, 0, 256);
      mem[255] = 8'h5B;
      run("last_open", -1, 0, 1, 2, 255, 256);
      mem[254] = 8'h5B;
      mem[255] = 8'h5D;
      run("last_close", -1, 1, 0, 0, 0, 257);

      fill(8'h2B);
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      repeat (5) @(posedge clk);
      #2;
      nrst = 1'b0;
      #1;
      chk("midrst_busy", int'(bus.busy), 0);
      chk("midrst_prog_addr", int'(bus.prog_addr), 0);
      chk("midrst_jt_wr", int'(bus.jt_wr), 0);
      sbq.delete();
      @(negedge clk);
      chk("midrst_hold_busy", int'(bus.busy), 0);
      nrst = 1'b1;
      load_str("+[-]");
      run("after_rst", -1, 1, 0, 0, 0, 6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/bf_jump_linker.md
Name: bf_jump_linker

Overview:
- Pre-run sequencer for the brainfuck interpreter core.
- After the program text has been loaded into program memory and before execution starts, it scans the program once and fills a jump table: for every `[` at address a, matched with `]` at address b, it writes jt[a]=b and jt[b]=a.
- The execution controller then resolves loops in one cycle instead of counting brackets.
- It reports unbalanced programs and stack overflow instead of linking them.

Parameters:
- AW, 8: address width of program memory and jump table.
- DEPTH, 16: maximum bracket nesting depth (stack entries).
- SPW, 5: stack pointer width, must satisfy 2^SPW > DEPTH.

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- start  in  1  begin a scan; sampled only in IDLE, DONE or ERR.
- busy  out  1  high in SCAN and LINK.
- done  out  1  scan completed with balanced brackets; held until next accepted start.
- err  out  1  scan aborted; held until next accepted start.
- err_code  out  2  1 = stray `]`, 2 = unclosed `[`, 3 = nesting overflow; 0 when err=0.
- err_addr  out  AW  program address where the error was detected.
- prog_addr  out  AW  program memory read address (combinational-read memory).
- prog_data  in  8  byte at prog_addr, same cycle.
- jt_wr  out  1  jump table write enable, written at the next rising edge.
- jt_addr  out  AW  jump table write address.
- jt_data  out  AW  jump table write data.

Behaviour:
- Clock and reset: single clock clk; nrst is asynchronous and active-low.
- Reset (nrst=0, asynchronous):
  - state=IDLE, pc=0, sp=0.
  - busy=done=err=jt_wr=0; err_code=0, err_addr=0, prog_addr=0.
- prog_addr=pc at all times.
- Characters: `[`=0x5B, `]`=0x5D, END=0x00. All other bytes are ignored, pc++.
- IDLE/DONE/ERR: start=1 → SCAN with pc=0, sp=0; done, err and err_code cleared at the same edge. start=0 → hold.
- SCAN, one byte per cycle:
  - `[`, sp<DEPTH: push pc, sp++, pc++.
  - `[`, sp==DEPTH: → ERR, code 3, err_addr=pc.
  - `]`, sp==0: → ERR, code 1, err_addr=pc.
  - `]`, sp>0: jt_wr=1, jt_addr=pc, jt_data=stack[sp-1]; → LINK.
  - END or the last address (pc=2^AW-1, after processing that byte as above): sp==0 → DONE; sp>0 → ERR, code 2, err_addr=stack[sp-1] (innermost unclosed).
- LINK (exactly one cycle): jt_wr=1, jt_addr=stack[sp-1], jt_data=pc; sp--, pc++; → SCAN.
- Latency: 1 cycle per non-`]` byte, 2 cycles per `]`.
- jt_wr is never asserted outside SCAN/LINK. Memory contents are not read back.
- pc never wraps: reaching the last address ends the scan.
- start while busy: ignored, scan continues undisturbed.
- Reset mid-scan: immediate abort. The jump table may be partially written; the next start rewrites all linked entries.
- Unlinked jump table entries are don't-care. The jump table is not cleared.

Test Plan:
- Balanced program: load "+[-]" then END (0x2B 0x5B 0x2D 0x5D 0x00), pulse start → exactly two jt writes, jt[3]=1 at edge 4 and jt[1]=3 at edge 5 after start. done=1 at edge 6, busy=0, err=0.
- Nested loops: load "[[]][]" then END → writes, in order, (2→1),(1→2),(3→0),(0→3),(5→4),(4→5); done=1 after 10 cycles, sp returns to 0.
- Stray `]`: load "+]" then END → err=1, err_code=1, err_addr=1, no jt_wr ever asserted, done=0.
- Unclosed `[`: load "[[]" then END → err=1, err_code=2, err_addr=0, one link pair written (2↔1).
- Overflow and restart: DEPTH=16, load 17×`[` → err_code=3, err_addr=16. Reload a balanced program, pulse start → err and err_code cleared at the start edge, done=1 at the end.
- Reset and ignored start: drop nrst mid-scan → busy=0 and state IDLE immediately, without a clock. Pulse start during busy → no effect on pc or cycle count.
